// File: rtl/dot_pkg.sv
// Shared constants, FSM state encoding and the per-axis bounce helper
// for the bouncing-dot trail generator.
package dot_pkg;

    localparam int BMP_SIZE = 128;
    localparam int ADDR_W   = 14;
    localparam int COORD_W  = 7;
    localparam int REFR_ROW = 481;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        MOVE,
        WRITE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] coord;
        logic               neg;
    } axis_t;

    // One step along one axis: reflect at either wall, never wrap.
    function automatic axis_t bounce(input logic [COORD_W-1:0] c, input logic neg);
        axis_t                    r;
        logic signed [COORD_W:0]  step;
        logic signed [COORD_W:0]  sum;
        step = neg ? -8'sd1 : 8'sd1;
        sum  = $signed({1'b0, c}) + step;
        if (!neg && c == COORD_W'(BMP_SIZE - 1)) begin
            r.coord = COORD_W'(BMP_SIZE - 2);
            r.neg   = 1'b1;
        end else if (neg && c == '0) begin
            r.coord = COORD_W'(1);
            r.neg   = 1'b0;
        end else begin
            r.coord = sum[COORD_W-1:0];
            r.neg   = neg;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_bitmap_ram.sv
// 1-bit-wide bitmap store: one synchronous write port, one synchronous
// read port with single-clock latency, no reset on the array.
module dot_bitmap_ram
    import dot_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dot_trail_gen.sv
// Bouncing dot that leaves a persistent trail in a 128x128 bitmap window,
// moved once per frame and rendered into the pixel stream.
module dot_trail_gen
    import dot_pkg::*;
#(
    parameter int X_ORG = 256,
    parameter int Y_ORG = 176
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic [2:0] sw,
    input  logic       video_on,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [2:0] bit_rgb
);

    logic [COORD_W-1:0] rel_x_p0, rel_y_p0;
    logic               in_region_p0;
    logic               refr_cond_p0;
    logic [ADDR_W-1:0]  rd_addr_p0;

    logic               video_on_p1, in_region_p1, refr_cond_p1;
    logic [1:0]         btn_p1;
    logic               rd_bit_p1;

    logic               refr_tick, clr_edge, seed_edge;

    state_t             state;
    logic [ADDR_W-1:0]  clr_addr;
    logic [COORD_W-1:0] dot_x, dot_y;
    logic               dx_neg, dy_neg;
    axis_t              nx, ny;

    logic               we;
    logic [ADDR_W-1:0]  wr_addr;
    logic               wr_data;

    // Stage p0: window decode from the live pixel position
    assign in_region_p0 = ({1'b0, pix_x} >= 11'(X_ORG)) && ({1'b0, pix_x} < 11'(X_ORG + BMP_SIZE)) &&
                          ({1'b0, pix_y} >= 11'(Y_ORG)) && ({1'b0, pix_y} < 11'(Y_ORG + BMP_SIZE));
    assign rel_x_p0     = pix_x[COORD_W-1:0] - COORD_W'(X_ORG);
    assign rel_y_p0     = pix_y[COORD_W-1:0] - COORD_W'(Y_ORG);
    assign rd_addr_p0   = {rel_y_p0, rel_x_p0};
    assign refr_cond_p0 = (pix_x == 10'd0) && (pix_y == 10'(REFR_ROW));

    // Stage p1: flags delayed to line up with the RAM read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_on_p1  <= 1'b0;
            in_region_p1 <= 1'b0;
            refr_cond_p1 <= 1'b0;
            btn_p1       <= 2'b00;
        end else begin
            video_on_p1  <= video_on;
            in_region_p1 <= in_region_p0;
            refr_cond_p1 <= refr_cond_p0;
            btn_p1       <= btn;
        end
    end

    assign refr_tick = refr_cond_p0 & ~refr_cond_p1;
    assign clr_edge  = btn[0] & ~btn_p1[0];
    assign seed_edge = btn[1] & ~btn_p1[1];

    dot_bitmap_ram #(.AW(ADDR_W)) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_p0),
        .rd_data (rd_bit_p1)
    );

    always_comb begin
        bit_rgb = 3'b000;
        if (video_on_p1) begin
            if (in_region_p1) begin
                bit_rgb = rd_bit_p1 ? sw : 3'b000;
            end else begin
                bit_rgb = 3'b010;
            end
        end
    end

    assign nx = bounce(dot_x, dx_neg);
    assign ny = bounce(dot_y, dy_neg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            dot_x    <= '0;
            dot_y    <= '0;
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b0;
        end else begin
            if (clr_edge) begin
                state    <= CLEAR;
                clr_addr <= '0;
            end else begin
                case (state)
                    CLEAR: begin
                        if (clr_addr == ADDR_W'(BMP_SIZE * BMP_SIZE - 1)) begin
                            state    <= IDLE;
                            clr_addr <= '0;
                        end else begin
                            clr_addr <= clr_addr + ADDR_W'(1);
                        end
                    end
                    IDLE: begin
                        if (refr_tick) begin
                            state <= MOVE;
                        end
                    end
                    MOVE: begin
                        state  <= WRITE;
                        dot_x  <= nx.coord;
                        dot_y  <= ny.coord;
                        dx_neg <= nx.neg;
                        dy_neg <= ny.neg;
                    end
                    default: state <= IDLE;
                endcase
            end
            // Placed last so a reseed overrides a coincident move.
            if (seed_edge) begin
                dot_x <= pix_x[COORD_W-1:0];
                dot_y <= pix_y[COORD_W-1:0];
            end
        end
    end

    always_comb begin
        we      = 1'b0;
        wr_addr = clr_addr;
        wr_data = 1'b0;
        case (state)
            CLEAR: we = 1'b1;
            WRITE: begin
                we      = 1'b1;
                wr_addr = {dot_y, dot_x};
                wr_data = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dot_trail_gen.sv
// Directed bench for dot_trail_gen: clear timing, reseed, bounce,
// clear-vs-tick priority, blanking, output latency and reset mid-clear.
module tb_dot_trail_gen;
    import dot_pkg::*;

    localparam int XO = 256;
    localparam int YO = 176;
    localparam int NCLR = 16384;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic [2:0] sw;
    logic       video_on;
    logic [9:0] pix_x, pix_y;
    logic [2:0] bit_rgb;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] exp_q[$];
    string      tag_q[$];

    dot_trail_gen #(.X_ORG(XO), .Y_ORG(YO)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .sw       (sw),
        .video_on (video_on),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .bit_rgb  (bit_rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic von, input logic [2:0] exp);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = von;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick(1);
        chk(tag_q.pop_front(), 32'(bit_rgb), 32'(exp_q.pop_front()));
    endtask

    task automatic seed(input int x, input int y);
        pix_x  = 10'(x);
        pix_y  = 10'(y);
        btn[1] = 1'b1;
        tick(1);
        btn[1] = 1'b0;
        pix_x  = 10'd1;
        pix_y  = 10'd0;
        tick(1);
    endtask

    // Condition held for three clocks: only its first clock may count as a tick.
    task automatic frame();
        pix_x = 10'd0;
        pix_y = 10'(REFR_ROW);
        tick(3);
        pix_x = 10'd1;
        pix_y = 10'd0;
        tick(3);
    endtask

    task automatic chk_dot(input string tag, input int x, input int y, input logic xn, input logic yn);
        chk({tag, "_x"},  32'(dut.dot_x),  32'(x));
        chk({tag, "_y"},  32'(dut.dot_y),  32'(y));
        chk({tag, "_dx"}, 32'(dut.dx_neg), 32'(xn));
        chk({tag, "_dy"}, 32'(dut.dy_neg), 32'(yn));
    endtask

    initial begin
        int nz;
        reset    = 1'b1;
        btn      = 2'b00;
        sw       = 3'b100;
        video_on = 1'b1;
        pix_x    = 10'd1;
        pix_y    = 10'd0;
        #1;
        chk("rst_rgb",   32'(bit_rgb),      32'd0);
        chk("rst_state", 32'(dut.state),    32'(CLEAR));
        chk("rst_addr",  32'(dut.clr_addr), 32'd0);
        chk_dot("rst", 0, 0, 1'b0, 1'b0);
        tick(2);
        reset = 1'b0;

        // Initial clear: exactly NCLR clocks in CLEAR
        tick(NCLR - 1);
        chk("clr_last_state", 32'(dut.state),    32'(CLEAR));
        chk("clr_last_addr",  32'(dut.clr_addr), 32'(NCLR - 1));
        tick(1);
        chk("clr_done_state", 32'(dut.state), 32'(IDLE));
        probe("clr_px_tl",  XO,       YO,       1'b1, 3'b000);
        probe("clr_px_br",  XO + 127, YO + 127, 1'b1, 3'b000);
        probe("clr_px_mid", XO + 64,  YO + 33,  1'b1, 3'b000);
        probe("out_right",  XO + 128, YO,       1'b1, 3'b010);
        probe("out_below",  XO,       YO + 128, 1'b1, 3'b010);

        // Reseed then one frame
        seed(5, 5);
        chk_dot("seed55", 5, 5, 1'b0, 1'b0);
        chk("seed_no_write", 32'(dut.state), 32'(IDLE));
        frame();
        chk_dot("move66", 6, 6, 1'b0, 1'b0);
        probe("dot66",    XO + 6, YO + 6, 1'b1, 3'b100);
        probe("seed55px", XO + 5, YO + 5, 1'b1, 3'b000);
        probe("left_out", XO - 1, YO,     1'b1, 3'b010);

        // Walls
        seed(127, 127);
        frame();
        chk_dot("wall_hi", 126, 126, 1'b1, 1'b1);
        probe("dot126", XO + 126, YO + 126, 1'b1, 3'b100);
        seed(0, 0);
        frame();
        chk_dot("wall_lo", 1, 1, 1'b0, 1'b0);
        probe("dot11", XO + 1, YO + 1, 1'b1, 3'b100);
        frame();
        chk_dot("step22", 2, 2, 1'b0, 1'b0);

        // Blanking and one-clock latency
        sw = 3'b011;
        probe("blank_set", XO + 6, YO + 6, 1'b0, 3'b000);
        probe("pre_out",   XO - 1, YO,     1'b1, 3'b010);
        pix_x = 10'(XO + 6);
        pix_y = 10'(YO + 6);
        #1;
        chk("latency_old", 32'(bit_rgb), 32'(3'b010));
        exp_q.push_back(3'b011);
        tag_q.push_back("latency_new");
        tick(1);
        chk(tag_q.pop_front(), 32'(bit_rgb), 32'(exp_q.pop_front()));

        // Clear edge coincident with refresh tick
        pix_x  = 10'd0;
        pix_y  = 10'(REFR_ROW);
        btn[0] = 1'b1;
        tick(1);
        btn[0] = 1'b0;
        chk("clr_win_state", 32'(dut.state),    32'(CLEAR));
        chk("clr_win_addr",  32'(dut.clr_addr), 32'd1 - 32'd1);
        chk_dot("clr_win", 2, 2, 1'b0, 1'b0);
        pix_x = 10'd1;
        pix_y = 10'd0;
        tick(2);
        pix_x = 10'd0;
        pix_y = 10'(REFR_ROW);
        tick(2);
        pix_x = 10'd1;
        pix_y = 10'd0;
        tick(NCLR - 5);
        chk("clr2_last", 32'(dut.state), 32'(CLEAR));
        tick(1);
        chk("clr2_done", 32'(dut.state), 32'(IDLE));
        tick(3);
        chk("no_queued_move", 32'(dut.state), 32'(IDLE));
        chk_dot("clr2_dot", 2, 2, 1'b0, 1'b0);
        nz = 0;
        for (int i = 0; i < NCLR; i++) begin
            if (dut.u_ram.mem[i] !== 1'b0) nz++;
        end
        chk("clr2_allzero", 32'(nz), 32'd0);
        probe("clr2_px66", XO + 6,   YO + 6,   1'b1, 3'b000);
        probe("clr2_px126", XO + 126, YO + 126, 1'b1, 3'b000);
        probe("clr2_px22", XO + 2,   YO + 2,   1'b1, 3'b000);

        // Reset in the middle of a clear
        btn[0] = 1'b1;
        tick(1);
        btn[0] = 1'b0;
        for (int i = 0; i < 20000 && dut.clr_addr != ADDR_W'(8000); i++) tick(1);
        chk("reach_8000", 32'(dut.clr_addr), 32'd8000);
        reset = 1'b1;
        #1;
        chk("rst_mid_addr",  32'(dut.clr_addr), 32'd0);
        chk("rst_mid_state", 32'(dut.state),    32'(CLEAR));
        chk("rst_mid_rgb",   32'(bit_rgb),      32'd0);
        chk_dot("rst_mid", 0, 0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(NCLR - 1);
        chk("clr3_last", 32'(dut.state), 32'(CLEAR));
        tick(1);
        chk("clr3_done", 32'(dut.state), 32'(IDLE));
        probe("clr3_px", XO + 10, YO + 20, 1'b1, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
